// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the five-stage pipeline hazard controller.
// Holds the FSM state encoding and the register-file index width.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  // Writes to r0 are discarded, so a load into r0 never creates a dependency.
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FREEZE   = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-detection inputs and pipeline-register keep/flush controls.
// The pipeline drives this bundle as master; the controller is the slave.
interface pipeline_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_mdu;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             ex_redirect;
  logic             imem_wait;
  logic             dmem_wait;
  logic             mdu_busy;

  logic             pc_keep;
  logic             if_id_keep;
  logic             id_ex_keep;
  logic             ex_mem_keep;
  logic             mem_wb_keep;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pc_sel_target;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu, ex_mem_read,
           ex_rt, ex_redirect, imem_wait, dmem_wait, mdu_busy,
    input  pc_keep, if_id_keep, id_ex_keep, ex_mem_keep, mem_wb_keep,
           if_id_flush, id_ex_flush, pc_sel_target
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu, ex_mem_read,
           ex_rt, ex_redirect, imem_wait, dmem_wait, mdu_busy,
    output pc_keep, if_id_keep, id_ex_keep, ex_mem_keep, mem_wb_keep,
           if_id_flush, id_ex_flush, pc_sel_target
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: combinational keep/flush
// decisions, a small state register, saturating statistics and a freeze watchdog.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz,
  input  logic                   stat_clr,
  output logic [1:0]             state_o,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt,
  output logic                   hang_err
);

  localparam int FRZ_W = $clog2(WDOG_LIMIT + 1);

  state_t           state_q;
  state_t           state_nxt;
  logic             mw;
  logic             lu;
  logic             mdu_stall;
  logic             pc_keep, if_id_keep, id_ex_keep, ex_mem_keep, mem_wb_keep;
  logic             if_id_flush, id_ex_flush, pc_sel_target;
  logic             stall_inc;
  logic [FRZ_W-1:0] frz_cnt;

  assign mw        = hz.imem_wait | hz.dmem_wait;
  assign lu        = hz.ex_mem_read && (hz.ex_rt != REG_ZERO) &&
                     ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                      (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));
  assign mdu_stall = hz.id_is_mdu & hz.mdu_busy;

  // Priority chain; a held EX keeps its redirect pending until the freeze ends.
  always_comb begin
    pc_keep       = 1'b0;
    if_id_keep    = 1'b0;
    id_ex_keep    = 1'b0;
    ex_mem_keep   = 1'b0;
    mem_wb_keep   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    pc_sel_target = 1'b0;
    state_nxt     = ST_RUN;
    if (mw) begin
      pc_keep     = 1'b1;
      if_id_keep  = 1'b1;
      id_ex_keep  = 1'b1;
      ex_mem_keep = 1'b1;
      mem_wb_keep = 1'b1;
      state_nxt   = ST_FREEZE;
    end else if (hz.ex_redirect) begin
      pc_sel_target = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (lu) begin
      pc_keep     = 1'b1;
      if_id_keep  = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mdu_stall) begin
      pc_keep     = 1'b1;
      if_id_keep  = 1'b1;
      id_ex_flush = 1'b1;
      state_nxt   = ST_MDU_WAIT;
    end
  end

  assign hz.pc_keep       = pc_keep;
  assign hz.if_id_keep    = if_id_keep;
  assign hz.id_ex_keep    = id_ex_keep;
  assign hz.ex_mem_keep   = ex_mem_keep;
  assign hz.mem_wb_keep   = mem_wb_keep;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.pc_sel_target = pc_sel_target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  assign state_o   = state_q;
  assign stall_inc = pc_keep & ~pc_sel_target;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stat_clr),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stat_clr),
    .inc   (pc_sel_target),
    .cnt   (flush_cnt)
  );

  // Counts consecutive memory-wait cycles; any other cycle restarts the run.
  sat_counter #(.WIDTH(FRZ_W)) u_frz_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (~mw),
    .inc   (mw),
    .cnt   (frz_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hang_err <= 1'b0;
    end else if (stat_clr) begin
      hang_err <= 1'b0;
    end else if (mw && (frz_cnt >= FRZ_W'(WDOG_LIMIT - 1))) begin
      hang_err <= 1'b1;
    end
  end

endmodule
